// File: rtl/branch_predict_unit.sv
// Branch prediction and next-PC select unit.
// A table of 2-bit saturating counters gives a zero-latency prediction for the
// fetch PC. The execute stage resolves branches and picks the next-PC source
// with priority interrupt > mret > opcode decode.
// Optional macro BPU_PERF_CNT_EN: enables the resolved-branch and mispredict
// counters. Without it both count outputs are tied to zero.
module branch_predict_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int INDEX_LSB   = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [XLEN-1:0] IF_PC,
   output logic            PRED_TAKEN,
   input  logic            EX_VALID,
   input  logic [XLEN-1:0] EX_PC,
   input  logic [31:0]     EX_INSTR,
   input  logic            EX_PRED_TAKEN,
   input  logic [XLEN-1:0] RS1,
   input  logic [XLEN-1:0] RS2,
   input  logic            INTR,
   input  logic            MRET_EXEC,
   input  logic            STALL,
   output logic [2:0]      pcSource,
   output logic            int_taken,
   output logic            flush,
   output logic [31:0]     MISPRED_CNT,
   output logic [31:0]     BRANCH_CNT
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] PCS_SEQ   = 3'd0;
   localparam logic [2:0] PCS_JALR  = 3'd1;
   localparam logic [2:0] PCS_BR    = 3'd2;
   localparam logic [2:0] PCS_JAL   = 3'd3;
   localparam logic [2:0] PCS_TRAP  = 3'd4;
   localparam logic [2:0] PCS_MRET  = 3'd5;
   localparam logic [2:0] PCS_RECOV = 3'd6;

   logic [IDX_W-1:0]         if_idx;
   logic [IDX_W-1:0]         ex_idx;
   logic [2*BHT_ENTRIES-1:0] ctr_flat;
   logic [6:0]               opcode;
   logic [2:0]               funct3;
   logic                     is_branch;
   logic                     actual_taken;
   logic                     mispred;
   logic                     update_en;

   assign if_idx = IF_PC[INDEX_LSB +: IDX_W];
   assign ex_idx = EX_PC[INDEX_LSB +: IDX_W];
   assign opcode = EX_INSTR[6:0];
   assign funct3 = EX_INSTR[14:12];

   // Only the index bits of the PCs and the opcode/funct3 fields matter.
   logic unused_bits;
   assign unused_bits = ^{IF_PC, EX_PC, EX_INSTR};

   // Prediction is the upper bit of the selected counter; counters hold 01
   // during reset so this reads 0 there.
   assign PRED_TAKEN = ctr_flat[{if_idx, 1'b1}];

   // Branch resolution, next-PC select, flush and update enable.
   always_comb begin
      is_branch    = 1'b0;
      actual_taken = 1'b0;
      pcSource     = PCS_SEQ;
      int_taken    = 1'b0;
      if (opcode == OP_BRANCH) begin
         is_branch = 1'b1;
         case (funct3)
            3'b000:  actual_taken = (RS1 == RS2);
            3'b001:  actual_taken = (RS1 != RS2);
            3'b100:  actual_taken = ($signed(RS1) <  $signed(RS2));
            3'b101:  actual_taken = ($signed(RS1) >= $signed(RS2));
            3'b110:  actual_taken = (RS1 <  RS2);
            3'b111:  actual_taken = (RS1 >= RS2);
            default: is_branch    = 1'b0;
         endcase
      end
      mispred = actual_taken ^ EX_PRED_TAKEN;

      if (INTR) begin
         pcSource  = PCS_TRAP;
         int_taken = 1'b1;
      end else if (MRET_EXEC) begin
         pcSource = PCS_MRET;
      end else if (EX_VALID) begin
         if (opcode == OP_JAL) begin
            pcSource = PCS_JAL;
         end else if (opcode == OP_JALR) begin
            pcSource = PCS_JALR;
         end else if (is_branch && mispred) begin
            pcSource = actual_taken ? PCS_BR : PCS_RECOV;
         end
      end

      flush     = (pcSource != PCS_SEQ) && !STALL;
      update_en = EX_VALID && is_branch && !STALL && !INTR && !MRET_EXEC;
   end

   // One 2-bit saturating counter per table entry.
   generate
      for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
         logic [1:0] ctr_q;
         logic [1:0] ctr_d;

         // Saturating step toward the resolved outcome when this entry is hit.
         always_comb begin
            ctr_d = ctr_q;
            if (update_en && (ex_idx == IDX_W'(gi))) begin
               if (actual_taken) begin
                  if (ctr_q != 2'b11) ctr_d = ctr_q + 2'd1;
               end else begin
                  if (ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
               end
            end
         end

         // Counter register, weakly not-taken out of reset.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) ctr_q <= 2'b01;
            else     ctr_q <= ctr_d;
         end

         assign ctr_flat[2*gi +: 2] = ctr_q;
      end
   endgenerate

`ifdef BPU_PERF_CNT_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] branch_cnt_d;
   logic [31:0] mispred_cnt_q;
   logic [31:0] mispred_cnt_d;

   // Count every update cycle, and those whose prediction was wrong; both wrap.
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (update_en) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
         if (mispred) mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   // Performance count registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign BRANCH_CNT  = branch_cnt_q;
   assign MISPRED_CNT = mispred_cnt_q;
`else
   assign BRANCH_CNT  = 32'd0;
   assign MISPRED_CNT = 32'd0;
`endif

endmodule
